vga_err_mon: RTL and testbench

//  Consumes the VGA timing/error outputs of the striped gfx demo on the pixel

---
 rtl/vga_err_mon_pkg.sv | 27 ++
 rtl/vga_err_mon_stretch.sv | 41 ++++
 rtl/vga_err_mon.sv | 146 ++++++++++++++
 tb/tb_vga_err_mon.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vga_err_mon_pkg.sv
// Shared types and the saturating-increment helper for the VGA error monitor.
package vga_err_mon_pkg;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_TOTAL      = 2'd0,
    SEL_LAST       = 2'd1,
    SEL_WORST      = 2'd2,
    SEL_ERR_FRAMES = 2'd3
  } disp_sel_t;

  localparam int SAT_MAX_W = 64;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int width);
    logic [SAT_MAX_W-1:0] max_val;
    if (width >= SAT_MAX_W) max_val = '1;
    else                    max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    sat_inc = (val >= max_val) ? max_val : val + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/vga_err_mon_stretch.sv
// Reloadable down-counter that holds the error LED on for STRETCH_CYCLES
// clocks after the most recent error.
module vga_err_mon_stretch
  import vga_err_mon_pkg::*;
#(
  parameter int STRETCH_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic err,
  output logic led_err
);

  localparam int TW = $clog2(STRETCH_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          led_err_q, led_err_d;

  always_comb begin
    timer_d = timer_q;
    if (clr)                  timer_d = '0;
    else if (err)             timer_d = TW'(STRETCH_CYCLES);
    else if (timer_q != '0)   timer_d = timer_q - TW'(1);
    // Registered from the next timer value so the LED rises the cycle after the error.
    led_err_d = (timer_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q   <= '0;
      led_err_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      led_err_q <= led_err_d;
    end
  end

  assign led_err = led_err_q;

endmodule

// File: rtl/vga_err_mon.sv
// Underflow statistics monitor for the VGA display stage. Optional per-frame
// worst/error-frame stats are enabled by defining VGA_ERR_MON_FRAME_STATS_EN.
// Board wiring: disp_val[15:8] -> R_I, disp_val[7:0] -> R_H, led_err -> LED1, led_frame -> LED2.
module vga_err_mon
  import vga_err_mon_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int STRETCH_CYCLES = 2_500_000,
  parameter bit VSYNC_ACT_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vga_vsync,
  input  logic                 vga_error,
  input  logic                 clr,
  input  logic [1:0]           disp_sel,
  output logic [CNT_WIDTH-1:0] disp_val,
  output logic                 led_err,
  output logic                 led_frame
);

  localparam logic VS_ACT = VSYNC_ACT_LOW ? 1'b0 : 1'b1;

  function automatic logic [CNT_WIDTH-1:0] inc(input logic [CNT_WIDTH-1:0] v);
    return CNT_WIDTH'(sat_inc(SAT_MAX_W'(v), CNT_WIDTH));
  endfunction

  logic                 vs_in_act;
  logic                 vs_act_q, vs_act_d;
  logic                 fb_q, fb_d;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] total_q, total_d;
  logic [CNT_WIDTH-1:0] frame_q, frame_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] last_val;
  logic                 led_frame_q, led_frame_d;
  logic [CNT_WIDTH-1:0] disp_val_q, disp_val_d;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
  logic [CNT_WIDTH-1:0] worst_q, worst_d;
  logic [CNT_WIDTH-1:0] err_frames_q, err_frames_d;
`endif

  assign vs_in_act = (vga_vsync == VS_ACT);

  always_comb begin
    vs_act_d    = vs_in_act;
    fb_d        = vs_in_act & ~vs_act_q;
    state_d     = state_q;
    total_d     = total_q;
    frame_d     = frame_q;
    last_d      = last_q;
    led_frame_d = led_frame_q;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
    worst_d      = worst_q;
    err_frames_d = err_frames_q;
`endif
    // An error on the boundary cycle still belongs to the frame that is ending.
    last_val = vga_error ? inc(frame_q) : frame_q;

    if (clr) begin
      state_d = SYNC_WAIT;
      total_d = '0;
      frame_d = '0;
      last_d  = '0;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
      worst_d      = '0;
      err_frames_d = '0;
`endif
    end else begin
      if (vga_error) total_d = inc(total_q);
      if (fb_q) begin
        led_frame_d = ~led_frame_q;
        frame_d     = '0;
        if (state_q == SYNC_WAIT) begin
          state_d = RUN;
        end else begin
          last_d = last_val;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
          if (last_val > worst_q) worst_d = last_val;
          if (last_val != '0)     err_frames_d = inc(err_frames_q);
`endif
        end
      end else if (state_q == RUN && vga_error) begin
        frame_d = inc(frame_q);
      end
    end

    // Mux the post-update values so the display tracks this cycle's changes.
    case (disp_sel_t'(disp_sel))
      SEL_TOTAL:      disp_val_d = total_d;
      SEL_LAST:       disp_val_d = last_d;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
      SEL_WORST:      disp_val_d = worst_d;
      SEL_ERR_FRAMES: disp_val_d = err_frames_d;
`else
      SEL_WORST:      disp_val_d = '0;
      SEL_ERR_FRAMES: disp_val_d = '0;
`endif
      default:        disp_val_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_act_q    <= 1'b0;
      fb_q        <= 1'b0;
      state_q     <= SYNC_WAIT;
      total_q     <= '0;
      frame_q     <= '0;
      last_q      <= '0;
      led_frame_q <= 1'b0;
      disp_val_q  <= '0;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
      worst_q      <= '0;
      err_frames_q <= '0;
`endif
    end else begin
      vs_act_q    <= vs_act_d;
      fb_q        <= fb_d;
      state_q     <= state_d;
      total_q     <= total_d;
      frame_q     <= frame_d;
      last_q      <= last_d;
      led_frame_q <= led_frame_d;
      disp_val_q  <= disp_val_d;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
      worst_q      <= worst_d;
      err_frames_q <= err_frames_d;
`endif
    end
  end

  vga_err_mon_stretch #(
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) u_stretch (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .err    (vga_error),
    .led_err(led_err)
  );

  assign disp_val  = disp_val_q;
  assign led_frame = led_frame_q;

endmodule

// File: tb/tb_vga_err_mon.sv
// Directed self-checking bench for vga_err_mon (CNT_WIDTH=8, STRETCH_CYCLES=4).
module tb_vga_err_mon;

  localparam int W = 8;
`ifdef VGA_ERR_MON_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vga_vsync = 1'b1;
  logic         vga_error = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   disp_sel = 2'd0;
  logic [W-1:0] disp_val;
  logic         led_err;
  logic         led_frame;

  int   checks = 0;
  int   failures = 0;
  logic lf_exp = 1'b0;

  always #5 clk = ~clk;

  vga_err_mon #(
    .CNT_WIDTH     (W),
    .STRETCH_CYCLES(4),
    .VSYNC_ACT_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vga_vsync(vga_vsync),
    .vga_error(vga_error),
    .clr      (clr),
    .disp_sel (disp_sel),
    .disp_val (disp_val),
    .led_err  (led_err),
    .led_frame(led_frame)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, return at the following negedge.
  task automatic cyc(input logic err, input logic vs);
    vga_error = err;
    vga_vsync = vs;
    @(negedge clk);
  endtask

  task automatic read(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    disp_sel = sel;
    cyc(1'b0, 1'b1);
    check(tag, 32'(disp_val), exp);
  endtask

  // vsync low for one cycle; the following cycle is the fb cycle.
  task automatic fb_pulse(input logic err_on_fb);
    cyc(1'b0, 1'b0);
    cyc(err_on_fb, 1'b1);
    lf_exp = ~lf_exp;
    check("led_frame_toggle", 32'(led_frame), 32'(lf_exp));
  endtask

  initial begin
    // 1. reset and pre-sync errors
    repeat (3) @(negedge clk);
    check("rst_disp_val", 32'(disp_val), 0);
    check("rst_led_err", 32'(led_err), 0);
    check("rst_led_frame", 32'(led_frame), 0);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) cyc(1'b1, 1'b1);
    read(2'd0, 3, "presync_total");
    fb_pulse(1'b0);
    read(2'd1, 0, "sync_fb_last");
    read(2'd0, 3, "sync_fb_total");

    // 2. frames with 5, 0, 2 errors
    repeat (5) cyc(1'b1, 1'b1);
    fb_pulse(1'b0);
    read(2'd1, 5, "frame5_last");
    fb_pulse(1'b0);
    read(2'd1, 0, "frame0_last");
    repeat (2) cyc(1'b1, 1'b1);
    fb_pulse(1'b0);
    read(2'd1, 2, "frame2_last");
    read(2'd2, STATS ? 5 : 0, "worst_after_3");
    read(2'd3, STATS ? 2 : 0, "errframes_after_3");
    read(2'd0, 10, "total_after_3");

    // 3. error on the fb cycle
    repeat (4) cyc(1'b1, 1'b1);
    fb_pulse(1'b1);
    read(2'd1, 5, "fb_err_last");
    read(2'd0, 15, "fb_err_total");
    fb_pulse(1'b0);
    read(2'd1, 0, "fb_err_new_frame");
    read(2'd3, STATS ? 3 : 0, "fb_err_errframes");

    // 4. saturation
    repeat (300) cyc(1'b1, 1'b1);
    read(2'd0, 255, "total_saturate");
    fb_pulse(1'b0);
    read(2'd1, 255, "frame_saturate");
    read(2'd2, STATS ? 255 : 0, "worst_saturate");
    read(2'd3, STATS ? 4 : 0, "errframes_sat");

    // 5. error LED stretch
    repeat (6) cyc(1'b0, 1'b1);
    check("led_err_idle", 32'(led_err), 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(i == 1, 1'b1);
      check($sformatf("stretch_single_p%0d", i), 32'(led_err), 32'(i <= 4));
    end
    repeat (2) cyc(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(i == 0 || i == 3, 1'b1);
      check($sformatf("stretch_ext_p%0d", i + 1), 32'(led_err), 32'(i <= 6));
    end

    // 6. clr with simultaneous error and fb
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    clr = 1'b1;
    cyc(1'b1, 1'b1);
    clr = 1'b0;
    check("clr_led_err", 32'(led_err), 0);
    check("clr_led_frame_held", 32'(led_frame), 32'(lf_exp));
    read(2'd0, 0, "clr_total");
    read(2'd1, 0, "clr_last");
    read(2'd2, 0, "clr_worst");
    read(2'd3, 0, "clr_errframes");
    repeat (2) cyc(1'b1, 1'b1);
    fb_pulse(1'b0);
    read(2'd1, 0, "post_clr_sync_last");
    read(2'd0, 2, "post_clr_total");
    cyc(1'b1, 1'b1);
    fb_pulse(1'b0);
    read(2'd1, 1, "post_clr_run_last");
    read(2'd2, STATS ? 1 : 0, "post_clr_worst");
    read(2'd3, STATS ? 1 : 0, "post_clr_errframes");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
